// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : display_pkg
// Purpose : Shared types, constants and helpers for the count_display block.
// Revision: 1.0  initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n sits at SEG_TABLE[n].
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = (s[4*i +: 4] >= 4'd5) ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg7_decoder
// Purpose : Combinational BCD nibble to active-low seven-segment pattern.
// Revision: 1.0  initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (nibble <= 4'd9)) begin
            seg = SEG_TABLE[nibble];
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
// ============================================================================
// Module  : count_display
// Purpose : 8-bit binary to BCD converter driving a 3-digit multiplexed display.
// Revision: 1.0  initial release
// ============================================================================
module count_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        busy
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam bit              LZ_EN    = (BLANK_LZ != 0);

    conv_state_t state;
    conv_state_t state_next;

    logic [7:0]       shreg;
    logic [11:0]      scratch;
    logic [11:0]      scratch_adj;
    logic [2:0]       iter;

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       nibble;
    logic             blank;
    logic [2:0]       an_next;
    logic [6:0]       seg_next;

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (iter == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign scratch_adj = dd_adjust(scratch);
    assign busy        = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= 8'd0;
            scratch <= 12'd0;
            iter    <= 3'd0;
            bcd     <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    shreg   <= value;
                    scratch <= 12'd0;
                    iter    <= 3'd0;
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj[10:0], shreg, 1'b0};
                    iter             <= iter + 3'd1;
                end
                DONE: begin
                    bcd <= scratch;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: the counter acts as an enable, never as a clock
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        nibble  = bcd[3:0];
        blank   = 1'b0;
        an_next = 3'b110;
        case (digit_idx)
            2'd1: begin
                nibble  = bcd[7:4];
                blank   = LZ_EN && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
                an_next = 3'b101;
            end
            2'd2: begin
                nibble  = bcd[11:8];
                blank   = LZ_EN && (bcd[11:8] == 4'd0);
                an_next = 3'b011;
            end
            default: ;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_next)
    );

    // an and seg come from the same registered bcd in one edge, so they never skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 3'b110;
            seg <= SEG_TABLE[0];
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, 50000, clk cycles per digit-scan slot (≥2).
REQ-002 SHALL have parameter BLANK_LZ, 1, leading-zero blanking enable (1=on).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port value  input  [7:0]  unsigned count to display, sampled by the converter.
REQ-006 SHALL have port bcd  output  [11:0]  registered BCD result {hundreds,tens,units}.
REQ-007 SHALL have port seg  output  [6:0]  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port an  output  [2:0]  digit enables, one-hot active-low; an[0]=units, an[2]=hundreds.
REQ-009 SHALL have port busy  output  1  high while converter is in SHIFT.

Function
REQ-010 Converter SHALL be an FSM with states IDLE, SHIFT, DONE, free-running, one state step per clk.
REQ-011 IDLE (1 cycle): latch value into an 8-bit shift register, clear 12-bit scratch, iteration count=0, go SHIFT.
REQ-012 SHIFT (8 cycles): each cycle add 3 to every scratch nibble ≥5, then shift {scratch,shiftreg} left by 1; after 8th shift go DONE.
REQ-013 DONE (1 cycle): copy scratch to bcd, go IDLE; full conversion period = 10 cycles.
REQ-014 Value changes during SHIFT/DONE SHALL NOT affect the current pass; new value taken at next IDLE.
REQ-015 bcd SHALL equal the decimal of value within 20 cycles of value becoming stable; max 12'h255, no other code out of 0–9 per nibble.
REQ-016 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap digit index advances 0→1→2→0.
REQ-017 an SHALL be 3'b110, 3'b101, 3'b011 for index 0,1,2; exactly one digit enabled every cycle.
REQ-018 seg SHALL show the bcd nibble for the current index, registered same cycle as an (no skew between them).
REQ-019 With BLANK_LZ=1: hundreds blank (seg=7'h7F) if hundreds=0; tens blank if hundreds=0 and tens=0; units never blank.
REQ-020 With BLANK_LZ=0 all three digits always shown.
REQ-021 Patterns (active-low gfedcba): 0=7'h40,1=7'h79,2=7'h24,3=7'h30,4=7'h19,5=7'h12,6=7'h02,7=7'h78,8=7'h00,9=7'h10; other codes 7'h7F.
REQ-022 bcd update and scan wrap in the same cycle: displayed digit SHALL use the updated bcd from the next cycle on; no glitch code.

Reset
REQ-023 rst SHALL force immediately: FSM=IDLE, shift register/scratch/iteration=0, bcd=12'h000, busy=0.
REQ-024 rst SHALL force scan counter=0, index=0, an=3'b110, seg=7'h40.
REQ-025 rst asserted mid-SHIFT SHALL abort the pass; after release first bcd update occurs 10 cycles later.

Structure
REQ-026 Package display_pkg SHALL hold the converter state enum (IDLE,SHIFT,DONE), SEG_BLANK=7'h7F and the 10-entry segment table.
REQ-027 Nibble-to-segment lookup SHALL be a sub-module seg7_decoder (combinational, 4-bit in, 7-bit out plus blank input).
REQ-028 Converter and scan logic SHALL live in count_display; no clock gating, no derived clocks (scan uses enable, not divided clock).

Verification
REQ-029 value=8'd0, reset release -> bcd=12'h000 after 10 cycles; units seg=7'h40, tens/hundreds seg=7'h7F.
REQ-030 value=8'd255 -> bcd=12'h255 within 20 cycles; busy high exactly 8 cycles per pass.
REQ-031 value=8'd9 then 8'd10 mid-SHIFT -> bcd=12'h009 first, then 12'h010 next pass; tens shows 7'h79.
REQ-032 SCAN_DIV=4 -> an sequence 110,101,011 each held 4 cycles, repeating, one-hot-low every cycle.
REQ-033 rst pulsed mid-SHIFT with value=8'd128 -> outputs at reset values immediately; bcd=12'h128 10 cycles after release.
REQ-034 Exhaustive sweep value 0..255 -> bcd matches decimal reference each pass, BLANK_LZ=0 and 1.
